// File: rtl/viterbi_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | viterbi_pkg : shared state encoding and saturating-increment helper        |
// | Revision    : 1.0                                                          |
// +----------------------------------------------------------------------------+
package viterbi_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WARMUP = 2'd1,
        TRACK  = 2'd2,
        FAULT  = 2'd3
    } state_t;

    // Callers size-cast the result back to their counter width (width <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max_v;
        max_v = 32'hFFFF_FFFF >> (32 - width);
        return (val >= max_v) ? val : val + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ref_bit_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ref_bit_fifo : DEPTHx1 reference-bit FIFO with empty-FIFO bypass           |
// | Revision     : 1.0                                                         |
// +----------------------------------------------------------------------------+
module ref_bit_fifo #(
    parameter int DEPTH = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic push,
    input  logic pop,
    input  logic din,
    output logic dout,
    output logic full,
    output logic empty
);

    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             bypass, wr_en, rd_en;

    assign empty  = (count_q == '0);
    assign full   = (count_q == FULL_CT);
    // An empty FIFO hands the incoming bit straight through as the reference.
    assign bypass = push && pop && empty;
    assign wr_en  = push && !bypass && (!full || pop);
    assign rd_en  = pop && !empty;
    assign dout   = empty ? din : mem_q[rd_ptr_q];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (wr_en) begin
                mem_d[wr_ptr_q] = din;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Storage contents are don't-care while empty, so only control is reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/viterbi_ber_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | viterbi_ber_checker : compares decoder output against buffered source bits |
// | Revision            : 1.0                                                  |
// +----------------------------------------------------------------------------+
module viterbi_ber_checker #(
    parameter int DEPTH  = 64,
    parameter int CW     = 16,
    parameter int WARMUP = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clear,
    input  logic          tx_valid,
    input  logic          tx_bit,
    input  logic          rx_valid,
    input  logic          rx_bit,
    output logic [CW-1:0] bit_ct,
    output logic [CW-1:0] err_ct,
    output logic          err_pulse,
    output logic          locked,
    output logic          fifo_ovf,
    output logic          fifo_unf
);

    import viterbi_pkg::*;

    localparam logic [CW-1:0] WARM_LIM = CW'(WARMUP);

    state_t        state_q, state_d;
    logic [CW-1:0] warm_q, warm_d;
    logic [CW-1:0] bit_ct_q, bit_ct_d;
    logic [CW-1:0] err_ct_q, err_ct_d;
    logic          err_pulse_q, err_pulse_d;
    logic          locked_q, locked_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic          fifo_push, fifo_pop, fifo_ref, fifo_full, fifo_empty;

    ref_bit_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clear (clear),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (tx_bit),
        .dout  (fifo_ref),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        warm_d      = warm_q;
        bit_ct_d    = bit_ct_q;
        err_ct_d    = err_ct_q;
        err_pulse_d = 1'b0;
        locked_d    = locked_q;
        ovf_d       = ovf_q;
        unf_d       = unf_q;
        fifo_push   = 1'b0;
        fifo_pop    = 1'b0;
        if (clear) begin
            state_d  = IDLE;
            warm_d   = '0;
            bit_ct_d = '0;
            err_ct_d = '0;
            locked_d = 1'b0;
            ovf_d    = 1'b0;
            unf_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (rx_valid) begin
                        unf_d   = 1'b1;
                        state_d = FAULT;
                    end else if (tx_valid) begin
                        fifo_push = 1'b1;
                        if (WARMUP > 0) begin
                            state_d = viterbi_pkg::WARMUP;
                        end else begin
                            state_d  = TRACK;
                            locked_d = 1'b1;
                        end
                    end
                end
                viterbi_pkg::WARMUP, TRACK: begin
                    if (rx_valid && !tx_valid && fifo_empty) begin
                        unf_d    = 1'b1;
                        state_d  = FAULT;
                        locked_d = 1'b0;
                    end else if (tx_valid && !rx_valid && fifo_full) begin
                        ovf_d    = 1'b1;
                        state_d  = FAULT;
                        locked_d = 1'b0;
                    end else begin
                        fifo_push = tx_valid;
                        fifo_pop  = rx_valid;
                        if (rx_valid) begin
                            if (state_q == TRACK) begin
                                bit_ct_d = CW'(sat_inc(32'(bit_ct_q), CW));
                                if (rx_bit != fifo_ref) begin
                                    err_ct_d    = CW'(sat_inc(32'(err_ct_q), CW));
                                    err_pulse_d = 1'b1;
                                end
                            end else begin
                                // Traceback warm-up: discard without comparing.
                                warm_d = warm_q + CW'(1);
                                if (warm_d == WARM_LIM) begin
                                    state_d  = TRACK;
                                    locked_d = 1'b1;
                                end
                            end
                        end
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            warm_q      <= '0;
            bit_ct_q    <= '0;
            err_ct_q    <= '0;
            err_pulse_q <= 1'b0;
            locked_q    <= 1'b0;
            ovf_q       <= 1'b0;
            unf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            bit_ct_q    <= bit_ct_d;
            err_ct_q    <= err_ct_d;
            err_pulse_q <= err_pulse_d;
            locked_q    <= locked_d;
            ovf_q       <= ovf_d;
            unf_q       <= unf_d;
        end
    end

    assign bit_ct    = bit_ct_q;
    assign err_ct    = err_ct_q;
    assign err_pulse = err_pulse_q;
    assign locked    = locked_q;
    assign fifo_ovf  = ovf_q;
    assign fifo_unf  = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_viterbi_ber_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_viterbi_ber_checker : three checker configurations on shared stimulus   |
// | Revision               : 1.0                                               |
// +----------------------------------------------------------------------------+
module tb_viterbi_ber_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clear, tx_valid, tx_bit, rx_valid, rx_bit;

    // Instance 0: defaults, 1: WARMUP=8, 2: CW=4
    logic [15:0] bit_o [3];
    logic [15:0] err_o [3];
    logic        pulse_o [3];
    logic        lock_o [3];
    logic        ovf_o [3];
    logic        unf_o [3];
    logic [3:0]  s_bit, s_err;

    assign bit_o[2] = {12'd0, s_bit};
    assign err_o[2] = {12'd0, s_err};

    viterbi_ber_checker #(.DEPTH(64), .CW(16), .WARMUP(0)) dut_a (
        .clk(clk), .rst(rst), .clear(clear), .tx_valid(tx_valid), .tx_bit(tx_bit),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .bit_ct(bit_o[0]), .err_ct(err_o[0]),
        .err_pulse(pulse_o[0]), .locked(lock_o[0]), .fifo_ovf(ovf_o[0]), .fifo_unf(unf_o[0]));

    viterbi_ber_checker #(.DEPTH(64), .CW(16), .WARMUP(8)) dut_w (
        .clk(clk), .rst(rst), .clear(clear), .tx_valid(tx_valid), .tx_bit(tx_bit),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .bit_ct(bit_o[1]), .err_ct(err_o[1]),
        .err_pulse(pulse_o[1]), .locked(lock_o[1]), .fifo_ovf(ovf_o[1]), .fifo_unf(unf_o[1]));

    viterbi_ber_checker #(.DEPTH(64), .CW(4), .WARMUP(0)) dut_s (
        .clk(clk), .rst(rst), .clear(clear), .tx_valid(tx_valid), .tx_bit(tx_bit),
        .rx_valid(rx_valid), .rx_bit(rx_bit), .bit_ct(s_bit), .err_ct(s_err),
        .err_pulse(pulse_o[2]), .locked(lock_o[2]), .fifo_ovf(ovf_o[2]), .fifo_unf(unf_o[2]));

    // Reference model: 0 idle, 1 warm-up, 2 track, 3 fault
    localparam int WU [3] = '{0, 8, 0};
    localparam int MX [3] = '{65535, 65535, 15};
    bit         refq[$];
    int         m_st [3];
    int         m_warm [3];
    int         m_bit [3];
    int         m_err [3];
    int         m_ovf, m_unf;
    int         pulse_cnt [3];
    logic [2:0] exp_pulse_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        refq.delete();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_warm[k] = 0; m_bit[k] = 0; m_err[k] = 0;
        end
        m_ovf = 0;
        m_unf = 0;
    endfunction

    function automatic void model_step(bit tv, bit tb, bit rv, bit rb);
        logic [2:0] p = 3'b000;
        bit         r = 1'b0;
        bit         byp;
        if (clear) begin
            model_reset();
        end else if (m_st[0] == 0) begin
            if (rv) begin
                m_unf = 1;
                for (int k = 0; k < 3; k++) m_st[k] = 3;
            end else if (tv) begin
                refq.push_back(tb);
                for (int k = 0; k < 3; k++) m_st[k] = (WU[k] > 0) ? 1 : 2;
            end
        end else if (m_st[0] != 3) begin
            if (rv && !tv && refq.size() == 0) begin
                m_unf = 1;
                for (int k = 0; k < 3; k++) m_st[k] = 3;
            end else if (tv && !rv && refq.size() == 64) begin
                m_ovf = 1;
                for (int k = 0; k < 3; k++) m_st[k] = 3;
            end else begin
                byp = rv && tv && (refq.size() == 0);
                if (rv) r = byp ? tb : refq.pop_front();
                if (tv && !byp) refq.push_back(tb);
                if (rv) begin
                    for (int k = 0; k < 3; k++) begin
                        if (m_st[k] == 1) begin
                            m_warm[k]++;
                            if (m_warm[k] == WU[k]) m_st[k] = 2;
                        end else if (m_st[k] == 2) begin
                            if (m_bit[k] < MX[k]) m_bit[k]++;
                            if (rb != r) begin
                                if (m_err[k] < MX[k]) m_err[k]++;
                                p[k] = 1'b1;
                            end
                        end
                    end
                end
            end
        end
        exp_pulse_q.push_back(p);
    endfunction

    task automatic check_all();
        logic [2:0] p;
        if (exp_pulse_q.size() == 0) begin
            chk("scoreboard_underrun", 32'd0, 32'd1);
            p = 3'b000;
        end else begin
            p = exp_pulse_q.pop_front();
        end
        for (int k = 0; k < 3; k++) begin
            pulse_cnt[k] += int'(pulse_o[k]);
            chk($sformatf("err_pulse[%0d]", k), 32'(pulse_o[k]), 32'(p[k]));
            chk($sformatf("bit_ct[%0d]", k), 32'(bit_o[k]), 32'(m_bit[k]));
            chk($sformatf("err_ct[%0d]", k), 32'(err_o[k]), 32'(m_err[k]));
            chk($sformatf("locked[%0d]", k), 32'(lock_o[k]), 32'(m_st[k] == 2));
            chk($sformatf("fifo_ovf[%0d]", k), 32'(ovf_o[k]), 32'(m_ovf));
            chk($sformatf("fifo_unf[%0d]", k), 32'(unf_o[k]), 32'(m_unf));
        end
    endtask

    // Called at a negedge: drive, clock once, check at the next negedge.
    task automatic cyc(input bit tv, input bit tb, input bit rv, input bit rb);
        tx_valid = tv; tx_bit = tb; rx_valid = rv; rx_bit = rb;
        model_step(tv, tb, rv, rb);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_clear();
        clear = 1'b1;
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        clear = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("%s_bit[%0d]", tag, k), 32'(bit_o[k]), 32'd0);
            chk($sformatf("%s_err[%0d]", tag, k), 32'(err_o[k]), 32'd0);
            chk($sformatf("%s_pulse[%0d]", tag, k), 32'(pulse_o[k]), 32'd0);
            chk($sformatf("%s_lock[%0d]", tag, k), 32'(lock_o[k]), 32'd0);
            chk($sformatf("%s_ovf[%0d]", tag, k), 32'(ovf_o[k]), 32'd0);
            chk($sformatf("%s_unf[%0d]", tag, k), 32'(unf_o[k]), 32'd0);
        end
    endtask

    // tx bit c at cycle c, rx bit j at cycle j+lat; rx bits flo..fhi inverted.
    task automatic run_stream(input int n, input int lat, input int flo, input int fhi, input int abort_at);
        bit src [256];
        bit tv, tb, rv, rb;
        for (int k = 0; k < 3; k++) pulse_cnt[k] = 0;
        for (int c = 0; c < n + lat; c++) begin
            if (c == abort_at) begin
                tx_valid = 1'b0; rx_valid = 1'b0;
                #2 rst = 1'b0;
                #1 check_all_zero("async_rst");
                @(negedge clk);
                rst = 1'b1;
                model_reset();
                exp_pulse_q.delete();
                return;
            end
            tv = (c < n);
            tb = 1'b0;
            if (tv) begin
                tb     = 1'($urandom_range(0, 1));
                src[c] = tb;
            end
            rv = (c >= lat);
            rb = 1'b0;
            if (rv) rb = src[c-lat] ^ ((c - lat) >= flo && (c - lat) <= fhi);
            cyc(tv, tb, rv, rb);
        end
        tx_valid = 1'b0;
        rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; clear = 1'b0;
        tx_valid = 1'b0; tx_bit = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b1;

        // Clean link, 12-cycle decoder latency
        run_stream(200, 12, -1, -1, -1);
        chk("clean_bit_a", 32'(bit_o[0]), 32'd200);
        chk("clean_err_a", 32'(err_o[0]), 32'd0);
        chk("clean_pulses_a", 32'(pulse_cnt[0]), 32'd0);
        chk("clean_bit_w", 32'(bit_o[1]), 32'd192);
        chk("clean_bit_s_sat", 32'(bit_o[2]), 32'd15);

        // Single inverted bit at index 50
        do_clear();
        run_stream(200, 12, 50, 50, -1);
        chk("single_err_a", 32'(err_o[0]), 32'd1);
        chk("single_bit_a", 32'(bit_o[0]), 32'd200);
        chk("single_pulses_a", 32'(pulse_cnt[0]), 32'd1);

        // Warm-up discards the first 8 corrupted bits
        do_clear();
        run_stream(40, 3, 0, 7, -1);
        chk("warm_bit_w", 32'(bit_o[1]), 32'd32);
        chk("warm_err_w", 32'(err_o[1]), 32'd0);
        chk("warm_err_a", 32'(err_o[0]), 32'd8);
        chk("warm_lock_w", 32'(lock_o[1]), 32'd1);

        // Overflow on the 65th push, then frozen until clear
        do_clear();
        for (int i = 0; i < 64; i++) cyc(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        chk("ovf_before", 32'(ovf_o[0]), 32'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0);
        chk("ovf_set", 32'(ovf_o[0]), 32'd1);
        chk("ovf_lock", 32'(lock_o[0]), 32'd0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("ovf_frozen_bit", 32'(bit_o[0]), 32'd0);
        do_clear();
        check_all_zero("after_clear");

        // Underflow in IDLE
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("unf_idle", 32'(unf_o[0]), 32'd1);

        // Bypass on empty FIFO in TRACK, then occupancy must still be zero
        do_clear();
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b0);
        chk("bypass_err_a", 32'(err_o[0]), 32'd1);
        chk("bypass_no_unf", 32'(unf_o[0]), 32'd0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("bypass_then_unf", 32'(unf_o[0]), 32'd1);

        // Saturation: 20 inverted bits on the 4-bit instance
        do_clear();
        run_stream(20, 2, 0, 19, -1);
        chk("sat_err_s", 32'(err_o[2]), 32'd15);
        chk("sat_pulses_s", 32'(pulse_cnt[2]), 32'd20);
        chk("sat_err_a", 32'(err_o[0]), 32'd20);

        // Async reset mid-stream, then a fresh clean stream
        do_clear();
        run_stream(100, 12, -1, -1, 40);
        run_stream(30, 5, -1, -1, -1);
        chk("post_rst_bit_a", 32'(bit_o[0]), 32'd30);
        chk("post_rst_err_a", 32'(err_o[0]), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
